pll_reset_sequencer: RTL and testbench

//  Controls the on-chip PLL fed by the 3.579 MHz MSX clock. Drives the PLL RESET pin and watches LOCK.

---
 rtl/pll_reset_sequencer_pkg.sv | 25 ++
 rtl/pll_lock_sync.sv | 38 +++
 rtl/pll_reset_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer_pkg
// Description : Shared definitions for the PLL reset sequencer. Holds the
//               status field widths used by the debug register map and a
//               helper for sizing the shared sequencing counter.
// Revision    : 1.0  initial release
// ============================================================================
package pll_reset_sequencer_pkg;

    // Status field widths exposed through the debug register map
    localparam int c_retry_w    = 4;
    localparam int c_loss_cnt_w = 8;

    // Largest of three values; sizes the shared sequencing counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sync.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sync
// Description : Two-flop synchronizer bringing the asynchronous PLL LOCK
//               signal into the clk domain. Two cycles of latency, clears
//               to 0 under reset.
// Ports       : clk   - destination clock
//               reset - synchronous active-high reset
//               d     - asynchronous input
//               q     - synchronized output
// Revision    : 1.0  initial release
// ============================================================================
module pll_lock_sync
    import pll_reset_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Drives the PLL RESET pin, waits for LOCK with timeout and
//               retry, requires lock to be stable before releasing the core
//               reset, then releases the peripheral reset after a stagger.
//               Lock loss while released re-sequences from PLL reset.
// Ports       : clk             - PLL reference clock (MSX clock domain)
//               reset           - synchronous active-high reset
//               pll_lock        - PLL LOCK, asynchronous
//               pll_reset       - PLL RESET pin drive
//               core_reset      - CPU/bus core reset, active high
//               periph_reset    - peripheral reset, active high
//               pll_ready       - high only while running with stable lock
//               pll_fail        - sticky, set when retries are exhausted
//               retry_count     - failed attempts in current acquisition
//               lock_loss_count - lock-loss events, saturating
// Revision    : 1.0  initial release
// ============================================================================
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 4096,
    parameter int STABLE_CYCLES   = 256,   // must be >= 2
    parameter int RELEASE_STAGGER = 8,
    parameter int LOSS_FILTER     = 4,
    parameter int MAX_RETRY       = 7      // 1..15
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pll_lock,
    output logic                    pll_reset,
    output logic                    core_reset,
    output logic                    periph_reset,
    output logic                    pll_ready,
    output logic                    pll_fail,
    output logic [c_retry_w-1:0]    retry_count,
    output logic [c_loss_cnt_w-1:0] lock_loss_count
);

    localparam int c_cnt_w  = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES) + 1);
    localparam int c_filt_w = $clog2(LOSS_FILTER + 1);

    localparam logic [c_cnt_w-1:0]   c_rst_last    = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_to_last     = c_cnt_w'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that saw lock already counts as the first stable
    // cycle, so STABLE itself only needs STABLE_CYCLES-1 more.
    localparam logic [c_cnt_w-1:0]   c_stable_last = c_cnt_w'(STABLE_CYCLES - 2);
    localparam logic [c_cnt_w-1:0]   c_stag_last   = c_cnt_w'(RELEASE_STAGGER - 1);
    localparam logic [c_filt_w-1:0]  c_filt_last   = c_filt_w'(LOSS_FILTER - 1);
    localparam logic [c_retry_w-1:0] c_max_retry   = c_retry_w'(MAX_RETRY);

    localparam logic [2:0] c_st_pll_rst   = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_stable    = 3'd2;
    localparam logic [2:0] c_st_rel_core  = 3'd3;
    localparam logic [2:0] c_st_run       = 3'd4;
    localparam logic [2:0] c_st_fail      = 3'd5;

    logic                    w_lock_s;

    logic [2:0]              r_state,        w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt,          w_cnt_nxt;
    logic [c_filt_w-1:0]     r_filt,         w_filt_nxt;
    logic [c_retry_w-1:0]    r_retry,        w_retry_nxt;
    logic [c_loss_cnt_w-1:0] r_loss_cnt,     w_loss_cnt_nxt;
    logic                    r_pll_reset,    w_pll_reset_nxt;
    logic                    r_core_reset,   w_core_reset_nxt;
    logic                    r_periph_reset, w_periph_reset_nxt;
    logic                    r_pll_ready,    w_pll_ready_nxt;
    logic                    r_pll_fail,     w_pll_fail_nxt;
    logic [c_retry_w-1:0]    w_retry_inc;

    pll_lock_sync u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (w_lock_s)
    );

    assign w_retry_inc = r_retry + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_pll_rst;
            r_cnt          <= '0;
            r_filt         <= '0;
            r_retry        <= '0;
            r_loss_cnt     <= '0;
            r_pll_reset    <= 1'b1;
            r_core_reset   <= 1'b1;
            r_periph_reset <= 1'b1;
            r_pll_ready    <= 1'b0;
            r_pll_fail     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_filt         <= w_filt_nxt;
            r_retry        <= w_retry_nxt;
            r_loss_cnt     <= w_loss_cnt_nxt;
            r_pll_reset    <= w_pll_reset_nxt;
            r_core_reset   <= w_core_reset_nxt;
            r_periph_reset <= w_periph_reset_nxt;
            r_pll_ready    <= w_pll_ready_nxt;
            r_pll_fail     <= w_pll_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_filt_nxt         = '0;
        w_retry_nxt        = r_retry;
        w_loss_cnt_nxt     = r_loss_cnt;
        w_pll_reset_nxt    = r_pll_reset;
        w_core_reset_nxt   = r_core_reset;
        w_periph_reset_nxt = r_periph_reset;
        w_pll_ready_nxt    = r_pll_ready;
        w_pll_fail_nxt     = r_pll_fail;

        case (r_state)
            c_st_pll_rst: begin
                if (r_cnt == c_rst_last) begin
                    w_state_nxt     = c_st_wait_lock;
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_st_wait_lock: begin
                if (w_lock_s) begin
                    w_state_nxt = c_st_stable;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_to_last) begin
                    w_cnt_nxt       = '0;
                    w_retry_nxt     = w_retry_inc;
                    w_pll_reset_nxt = 1'b1;
                    if (w_retry_inc == c_max_retry) begin
                        w_state_nxt    = c_st_fail;
                        w_pll_fail_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_st_pll_rst;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_st_stable: begin
                // Any dropout restarts the lock wait; not a failed attempt
                if (!w_lock_s) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt      = c_st_rel_core;
                    w_cnt_nxt        = '0;
                    w_core_reset_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_st_rel_core, c_st_run: begin
                if (r_state == c_st_rel_core) begin
                    if (r_cnt == c_stag_last) begin
                        w_state_nxt        = c_st_run;
                        w_cnt_nxt          = '0;
                        w_periph_reset_nxt = 1'b0;
                        w_pll_ready_nxt    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                // Lock-loss filter; overrides the stagger step above
                if (!w_lock_s) begin
                    if (r_filt == c_filt_last) begin
                        w_state_nxt        = c_st_pll_rst;
                        w_cnt_nxt          = '0;
                        w_filt_nxt         = '0;
                        w_retry_nxt        = '0;
                        w_pll_reset_nxt    = 1'b1;
                        w_core_reset_nxt   = 1'b1;
                        w_periph_reset_nxt = 1'b1;
                        w_pll_ready_nxt    = 1'b0;
                        if (r_loss_cnt != '1) begin
                            w_loss_cnt_nxt = r_loss_cnt + 1'b1;
                        end
                    end else begin
                        w_filt_nxt = r_filt + 1'b1;
                    end
                end
            end

            c_st_fail: begin
                w_pll_reset_nxt    = 1'b1;
                w_core_reset_nxt   = 1'b1;
                w_periph_reset_nxt = 1'b1;
                w_pll_ready_nxt    = 1'b0;
                w_pll_fail_nxt     = 1'b1;
            end

            default: begin
                w_state_nxt        = c_st_pll_rst;
                w_cnt_nxt          = '0;
                w_pll_reset_nxt    = 1'b1;
                w_core_reset_nxt   = 1'b1;
                w_periph_reset_nxt = 1'b1;
                w_pll_ready_nxt    = 1'b0;
            end
        endcase
    end

    assign pll_reset       = r_pll_reset;
    assign core_reset      = r_core_reset;
    assign periph_reset    = r_periph_reset;
    assign pll_ready       = r_pll_ready;
    assign pll_fail        = r_pll_fail;
    assign retry_count     = r_retry;
    assign lock_loss_count = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer. Directed vector
//               table for clean lock, glitches, re-sequencing, unstable lock
//               and retry exhaustion; hand sequences for lock-loss counter
//               saturation and reset during core release.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pll_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic       core_reset;
    logic       periph_reset;
    logic       pll_ready;
    logic       pll_fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES  (4),
        .LOCK_TIMEOUT    (32),
        .STABLE_CYCLES   (8),
        .RELEASE_STAGGER (3),
        .LOSS_FILTER     (2),
        .MAX_RETRY       (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock        (pll_lock),
        .pll_reset       (pll_reset),
        .core_reset      (core_reset),
        .periph_reset    (periph_reset),
        .pll_ready       (pll_ready),
        .pll_fail        (pll_fail),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pll_reset, core_reset, periph_reset, pll_ready, pll_fail, retry, loss}
    logic [16:0] w_got;
    assign w_got = {pll_reset, core_reset, periph_reset, pll_ready, pll_fail,
                    retry_count, lock_loss_count};

    typedef struct {
        string       name;
        int          cycles;
        bit          rst;
        bit          lock;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [16:0] ex(input bit pr, input bit cr, input bit ppr,
                                       input bit rdy, input bit f,
                                       input int retry, input int loss);
        return {pr, cr, ppr, rdy, f, 4'(retry), 8'(loss)};
    endfunction

    function automatic vec_t mk(input string nm, input int n, input bit r,
                                input bit l, input logic [16:0] e);
        vec_t v;
        v.name = nm; v.cycles = n; v.rst = r; v.lock = l; v.exp = e;
        return v;
    endfunction

    // Advance n rising edges, ending on a falling edge (sample/drive point)
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string nm, input logic [16:0] e);
        checks++;
        if (w_got !== e) begin
            errors++;
            $display("FAIL %s: got pr/cr/ppr/rdy/fail=%b%b%b%b%b retry=%0d loss=%0d, expected %b%b%b%b%b retry=%0d loss=%0d",
                     nm, w_got[16], w_got[15], w_got[14], w_got[13], w_got[12],
                     w_got[11:8], w_got[7:0], e[16], e[15], e[14], e[13], e[12],
                     e[11:8], e[7:0]);
        end
    endtask

    // which=0: wait for pll_ready high; which=1: wait for core_reset low
    task automatic wait_sig(input string nm, input bit which, input int limit);
        int k;
        bit hit;
        k = 0;
        hit = which ? (core_reset === 1'b0) : (pll_ready === 1'b1);
        while (!hit && k < limit) begin
            step(1);
            k++;
            hit = which ? (core_reset === 1'b0) : (pll_ready === 1'b1);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, got pr/cr/ppr/rdy=%b%b%b%b, expected event",
                     nm, k, pll_reset, core_reset, periph_reset, pll_ready);
        end
    endtask

    initial begin
        logic [16:0] rst_v;
        rst_v = ex(1, 1, 1, 0, 0, 0, 0);

        // Clean lock (lock rises before edge 11, lock_s at 12, core at 20)
        vecs.push_back(mk("reset_state",   2, 1, 0, rst_v));
        vecs.push_back(mk("pllrst_hold",   3, 0, 0, rst_v));
        vecs.push_back(mk("pllrst_end",    1, 0, 0, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("wait_lock",     6, 0, 0, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("stable",        9, 0, 1, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("core_release",  1, 0, 1, ex(0, 0, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("stagger",       2, 0, 1, ex(0, 0, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("run",           1, 0, 1, ex(0, 0, 0, 1, 0, 0, 0)));
        vecs.push_back(mk("run_hold",      5, 0, 1, ex(0, 0, 0, 1, 0, 0, 0)));
        // One-cycle glitch is filtered out
        vecs.push_back(mk("glitch1",       1, 0, 0, ex(0, 0, 0, 1, 0, 0, 0)));
        vecs.push_back(mk("glitch1_after", 5, 0, 1, ex(0, 0, 0, 1, 0, 0, 0)));
        // Three-cycle low: lock_s low sampled at edges 37,38 -> trip at 38
        vecs.push_back(mk("loss_low",      3, 0, 0, ex(0, 0, 0, 1, 0, 0, 0)));
        vecs.push_back(mk("loss_trip",     1, 0, 1, ex(1, 1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk("reseq_pllrst",  3, 0, 1, ex(1, 1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk("reseq_wait",    1, 0, 1, ex(0, 1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk("reseq_stable",  7, 0, 1, ex(0, 1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk("reseq_core",    1, 0, 1, ex(0, 0, 1, 0, 0, 0, 1)));
        vecs.push_back(mk("reseq_stagger", 2, 0, 1, ex(0, 0, 1, 0, 0, 0, 1)));
        vecs.push_back(mk("reseq_run",     1, 0, 1, ex(0, 0, 0, 1, 0, 0, 1)));
        // Reset from RUN, then unstable lock (dropout inside STABLE)
        vecs.push_back(mk("reset_from_run",1, 1, 0, rst_v));
        vecs.push_back(mk("u_wait",       10, 0, 0, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("u_high5",       5, 0, 1, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("u_low1",        1, 0, 0, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("u_no_release",  9, 0, 1, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("u_core",        1, 0, 1, ex(0, 0, 1, 0, 0, 0, 0)));
        // Never lock: timeouts at edges 36, 72, 108
        vecs.push_back(mk("n_reset",       1, 1, 0, rst_v));
        vecs.push_back(mk("n_wait1",      35, 0, 0, ex(0, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("n_timeout1",    1, 0, 0, ex(1, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mk("n_pllrst2",     3, 0, 0, ex(1, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mk("n_wait2",       1, 0, 0, ex(0, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mk("n_wait2_hold", 31, 0, 0, ex(0, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mk("n_timeout2",    1, 0, 0, ex(1, 1, 1, 0, 0, 2, 0)));
        vecs.push_back(mk("n_round3",     35, 0, 0, ex(0, 1, 1, 0, 0, 2, 0)));
        vecs.push_back(mk("n_fail",        1, 0, 0, ex(1, 1, 1, 0, 1, 3, 0)));
        vecs.push_back(mk("n_fail_hold",  20, 0, 1, ex(1, 1, 1, 0, 1, 3, 0)));
        vecs.push_back(mk("fail_reset",    1, 1, 0, rst_v));

        reset    = 1'b1;
        pll_lock = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            pll_lock = vecs[i].lock;
            step(vecs[i].cycles);
            chk(vecs[i].name, vecs[i].exp);
        end

        // Saturation of the lock-loss counter
        reset = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            pll_lock = 1'b1;
            wait_sig("sat_wait_ready", 1'b0, 100);
            pll_lock = 1'b0;
            step(5);
            chk("sat_loss_count", ex(1, 1, 1, 0, 0, 0, (i > 255) ? 255 : i));
        end

        // Reset asserted during REL_CORE
        pll_lock = 1'b1;
        wait_sig("mid_wait_core", 1'b1, 100);
        chk("mid_rel_core", ex(0, 0, 1, 0, 0, 0, 255));
        step(1);
        reset = 1'b1;
        step(1);
        chk("mid_reset", rst_v);
        reset = 1'b0;
        step(3);
        chk("mid_pllrst_hold", rst_v);
        step(1);
        chk("mid_pllrst_end", ex(0, 1, 1, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
